add_serial2: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor that processes 2 bits per cycle through one 2-bit carry-lookahead cell.
- Sits upstream of that cell: it sequences operand digits and the running carry into the cell, then collects the sum digits and final carry.
- Serves as the low-area add path for multi-cycle units (iterative mul/div, address generation in small cores).
- Valid/ready handshakes on both input and output.

---
 rtl/add_serial2_pkg.sv | 19 +
 rtl/add_serial2_cla2_cell.sv | 20 ++
 rtl/add_serial2.sv | 121 ++++++++++++
 tb/tb_add_serial2.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/add_serial2_pkg.sv
// Shared types and sizing helpers for the 2-bit-per-cycle serial adder.
// The counter width is derived from the operand width.
package add_serial2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W = $clog2(DEFAULT_WIDTH / 2);

    // Digit counter width for an arbitrary WIDTH; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

endpackage

// File: rtl/add_serial2_cla2_cell.sv
// Two-bit carry-lookahead adder cell; purely combinational.
module cla2_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c,
    output logic [1:0] s,
    output logic       c_out
);

    logic [1:0] p;
    logic [1:0] g;
    logic       c1;

    assign p     = a ^ b;
    assign g     = a & b;
    assign c1    = g[0] | (c & p[0]);
    assign c_out = g[1] | (g[0] & p[1]) | (c & p[0] & p[1]);
    assign s     = {p[1] ^ c1, p[0] ^ c};

endmodule

// File: rtl/add_serial2.sv
// Multi-cycle adder/subtractor: feeds two operand bits per cycle through one
// cla2_cell and collects the sum digits, with valid/ready on both sides.
module add_serial2
    import add_serial2_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int             CNT_LEN = cnt_width(WIDTH);
    localparam logic [CNT_LEN-1:0] LAST_DIGIT = CNT_LEN'(WIDTH / 2 - 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry;
    logic [CNT_LEN-1:0] cnt;
    logic               a_msb;
    logic               b_msb;
    logic [1:0]         cell_s;
    logic               cell_c;

    cla2_cell u_cell (
        .a     (a_sh[1:0]),
        .b     (b_sh[1:0]),
        .c     (carry),
        .s     (cell_s),
        .c_out (cell_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_DIGIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is folded in at capture time: B is inverted once and the
    // carry chain starts at 1, so the RUN loop is identical for both ops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_sh  <= i_a;
                        b_sh  <= i_b ^ {WIDTH{i_sub}};
                        carry <= i_sub;
                        cnt   <= '0;
                        a_msb <= i_a[WIDTH-1];
                        b_msb <= i_b[WIDTH-1] ^ i_sub;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 2;
                    b_sh   <= b_sh >> 2;
                    sum_sh <= {cell_s, sum_sh[WIDTH-1:2]};
                    carry  <= cell_c;
                    cnt    <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit, then compared
    // with the carry out of the MSB to flag signed overflow.
    assign o_sum  = sum_sh;
    assign o_cout = carry;
    assign o_ovf  = a_msb ^ b_msb ^ sum_sh[WIDTH-1] ^ carry;

endmodule

// File: tb/tb_add_serial2.sv
// Directed bench for add_serial2: vector table plus hand-written sequences
// for backpressure, operand changes while busy and reset mid-operation.
`timescale 1ns/1ps
module tb_add_serial2;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH / 2 + 1;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;

    int nVectors   = 0;
    int nMiscompares = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    add_serial2 #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf)
    );

    task automatic checkOutput(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one request, wait for the result, hold i_ready low for 'hold'
    // cycles, then transfer. With 'disturb' set, inputs are scrambled and
    // i_valid kept high while the block is busy.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input int hold, input bit disturb,
                                 output logic [WIDTH-1:0] sum, output logic cout,
                                 output logic ovf, output int lat);
        bit readyOk;
        bit stableOk;
        readyOk  = 1'b1;
        stableOk = 1'b1;
        i_a      = a;
        i_b      = b;
        i_sub    = sub;
        i_valid  = 1'b1;
        i_ready  = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        if (!disturb) i_valid = 1'b0;
        while (!o_valid && lat < 100) begin
            if (o_ready) readyOk = 1'b0;
            if (disturb) begin
                i_a   = $urandom;
                i_b   = $urandom;
                i_sub = ~sub;
            end
            @(posedge clk); #1;
            lat++;
        end
        sum  = o_sum;
        cout = o_cout;
        ovf  = o_ovf;
        if (!o_valid) begin
            checkOutput("o_valid timeout", {{WIDTH{1'b0}}, o_valid}, 1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (o_valid !== 1'b1 || o_sum !== sum || o_cout !== cout || o_ovf !== ovf || o_ready !== 1'b0)
                stableOk = 1'b0;
        end
        if (hold > 0) checkOutput("stable under backpressure", {{WIDTH{1'b0}}, stableOk}, 1);
        if (disturb) checkOutput("o_ready low while busy", {{WIDTH{1'b0}}, readyOk}, 1);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        i_valid = 1'b0;
        checkOutput("ready/valid after transfer", {{(WIDTH-1){1'b0}}, o_ready, o_valid}, 2'b10);
    endtask

    initial begin
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               lat;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_sub   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        checkOutput("reset o_ready", {{WIDTH{1'b0}}, o_ready}, 1);
        checkOutput("reset o_valid", {{WIDTH{1'b0}}, o_valid}, 0);
        checkOutput("reset o_sum", {1'b0, o_sum}, 0);
        checkOutput("reset o_cout", {{WIDTH{1'b0}}, o_cout}, 0);
        checkOutput("reset o_ovf", {{WIDTH{1'b0}}, o_ovf}, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, 0, 1'b0, sum, cout, ovf, lat);
            checkOutput($sformatf("vec%0d sum", i), {1'b0, sum}, {1'b0, vecs[i].sum});
            checkOutput($sformatf("vec%0d cout", i), {{WIDTH{1'b0}}, cout}, {{WIDTH{1'b0}}, vecs[i].cout});
            checkOutput($sformatf("vec%0d ovf", i), {{WIDTH{1'b0}}, ovf}, {{WIDTH{1'b0}}, vecs[i].ovf});
            checkOutput($sformatf("vec%0d latency", i), (WIDTH+1)'(lat), (WIDTH+1)'(LATENCY));
        end

        applyStimulus(32'h0000_1000, 32'h0000_0234, 1'b0, 3, 1'b0, sum, cout, ovf, lat);
        checkOutput("backpressure sum", {1'b0, sum}, {1'b0, 32'h0000_1234});
        checkOutput("backpressure latency", (WIDTH+1)'(lat), (WIDTH+1)'(LATENCY));

        applyStimulus(32'd100, 32'd23, 1'b0, 2, 1'b1, sum, cout, ovf, lat);
        checkOutput("operand stability sum", {1'b0, sum}, {1'b0, 32'd123});
        checkOutput("operand stability cout", {{WIDTH{1'b0}}, cout}, 0);

        // Reset five digits into an operation; the result must be dropped.
        i_a     = 32'h0000_0011;
        i_b     = 32'h0000_0022;
        i_sub   = 1'b0;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        checkOutput("mid reset o_ready", {{WIDTH{1'b0}}, o_ready}, 1);
        checkOutput("mid reset o_valid", {{WIDTH{1'b0}}, o_valid}, 0);
        checkOutput("mid reset o_sum", {1'b0, o_sum}, 0);
        applyStimulus(32'd2, 32'd2, 1'b0, 0, 1'b0, sum, cout, ovf, lat);
        checkOutput("post reset sum", {1'b0, sum}, {1'b0, 32'd4});
        checkOutput("post reset latency", (WIDTH+1)'(lat), (WIDTH+1)'(LATENCY));

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
